// File: rtl/frame_mem_responder.sv
// Frame store answering the cartoonifier master's read/write requests with one-shot response pulses.
// Read response READ_LATENCY cycles after acceptance, write response WRITE_LATENCY cycles; the master holds its enable until the response (level handshake), and the host port is refused while any master enable is high.
module frame_mem_responder #(
    parameter int IMG_W         = 64,
    parameter int IMG_H         = 64,
    parameter int COL_STRIDE    = 6,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               master_read_enable,
    input  logic               master_write_enable,
    input  logic signed [31:0] read_row,
    input  logic signed [31:0] read_col,
    input  logic signed [31:0] read_col_const,
    input  logic signed [31:0] write_row,
    input  logic signed [31:0] write_col,
    input  logic signed [31:0] write_col_const,
    input  logic [31:0]        master_writedata,
    output logic [31:0]        master_readdata,
    output logic               master_readdatavalid,
    output logic               master_writeresponsevalid,
    input  logic               host_en,
    input  logic               host_we,
    input  logic [31:0]        host_addr,
    input  logic [31:0]        host_wdata,
    output logic [31:0]        host_rdata,
    output logic               host_ready,
    output logic               addr_err,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
);

    localparam int DEPTH   = IMG_W * IMG_H;
    localparam int AW      = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   lat_cnt;
    logic [AW-1:0]   lat_idx;
    logic            lat_ok;
    logic            serve_rd;
    logic            run_q;
    logic [31:0]     mem [DEPTH];

    logic signed [31:0] rd_col_eff;
    logic signed [31:0] wr_col_eff;
    logic               rd_ok;
    logic               wr_ok;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      host_idx;
    logic               host_ok;
    logic               acc_rd;
    logic               acc_wr;
    logic               host_acc;

    assign rd_col_eff = read_col + read_col_const * COL_STRIDE;
    assign wr_col_eff = write_col + write_col_const * COL_STRIDE;
    assign rd_ok  = (read_row >= 0) && (read_row < IMG_H) && (rd_col_eff >= 0) && (rd_col_eff < IMG_W);
    assign wr_ok  = (write_row >= 0) && (write_row < IMG_H) && (wr_col_eff >= 0) && (wr_col_eff < IMG_W);
    assign rd_idx = AW'(read_row * IMG_W + rd_col_eff);
    assign wr_idx = AW'(write_row * IMG_W + wr_col_eff);

    // run_q keeps the block inert (host_ready low, no acceptance) until the first edge after reset release.
    assign acc_rd     = run_q && (state == IDLE) && master_read_enable;
    assign acc_wr     = run_q && (state == IDLE) && master_write_enable && !master_read_enable;
    assign host_ready = run_q && (state == IDLE) && !master_read_enable && !master_write_enable;
    assign host_acc   = host_en && host_ready;
    assign host_idx   = AW'(host_addr);
    assign host_ok    = host_addr < 32'(DEPTH);

    // Master writes commit on the acceptance edge, so a later reset cannot undo them.
    always_ff @(posedge clk) begin
        if (acc_wr && wr_ok) begin
            mem[wr_idx] <= master_writedata;
        end else if (host_acc && host_we && host_ok) begin
            mem[host_idx] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                     <= IDLE;
            lat_cnt                   <= '0;
            lat_idx                   <= '0;
            lat_ok                    <= 1'b0;
            serve_rd                  <= 1'b0;
            run_q                     <= 1'b0;
            master_readdata           <= '0;
            master_readdatavalid      <= 1'b0;
            master_writeresponsevalid <= 1'b0;
            host_rdata                <= '0;
            addr_err                  <= 1'b0;
            rd_count                  <= '0;
            wr_count                  <= '0;
        end else begin
            run_q                     <= 1'b1;
            master_readdatavalid      <= 1'b0;
            master_writeresponsevalid <= 1'b0;

            if (host_acc && !host_we) begin
                host_rdata <= host_ok ? mem[host_idx] : '0;
            end

            case (state)
                IDLE: begin
                    if (acc_rd) begin
                        state    <= RD_WAIT;
                        serve_rd <= 1'b1;
                        lat_cnt  <= CW'(READ_LATENCY - 1);
                        lat_idx  <= rd_idx;
                        lat_ok   <= rd_ok;
                        if (!rd_ok) addr_err <= 1'b1;
                    end else if (acc_wr) begin
                        state    <= WR_WAIT;
                        serve_rd <= 1'b0;
                        lat_cnt  <= CW'(WRITE_LATENCY - 1);
                        if (!wr_ok) addr_err <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        master_readdatavalid <= 1'b1;
                        master_readdata      <= lat_ok ? mem[lat_idx] : '0;
                        rd_count             <= rd_count + 16'd1;
                        state                <= DRAIN;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (lat_cnt == '0) begin
                        master_writeresponsevalid <= 1'b1;
                        wr_count                  <= wr_count + 16'd1;
                        state                     <= DRAIN;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait for the served enable to drop so a held request is answered once.
                    if (serve_rd ? !master_read_enable : !master_write_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
